servo_pulse_decoder: RTL and testbench

//   Receive side of the hobby-servo PWM link: measures each high pulse on srv_i and recovers the N-bit position.

---
 rtl/servo_pkg.sv | 30 +++
 rtl/servo_in_sync.sv | 35 +++
 rtl/servo_pulse_decoder.sv | 173 +++++++++++++++++
 tb/tb_servo_pulse_decoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
`timescale 1ns/1ps
// servo_pkg: constants, state encoding, error codes and timing helpers shared
// by the servo pulse generator and decoder.
package servo_pkg;

  // Nanoseconds in one millisecond: the fixed pulse prefix and position span.
  localparam int unsigned MS_NS = 1_000_000;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    ARMED    = 2'd1,
    HIGH1MS  = 2'd2,
    MEASURE  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;

  // Clocks in one millisecond.
  function automatic int unsigned ms_cyc(input int unsigned clk_per_ns);
    return MS_NS / clk_per_ns;
  endfunction

  // Clocks per position step minus one: the millisecond split into 2**n steps.
  function automatic int unsigned tick_cyc(input int unsigned clk_per_ns,
                                           input int unsigned n);
    return ms_cyc(clk_per_ns) >> n;
  endfunction

endpackage

// File: rtl/servo_in_sync.sv
`timescale 1ns/1ps
// servo_in_sync: brings the asynchronous servo line into the clock domain and
// produces a one-cycle rise/fall strobe for each level change.
module servo_in_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic srv_i,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync_p0;
  logic sync_p1;
  logic lvl_p2;

  // Synchronizer and edge history; reset to high so a pulse already in
  // progress at reset release never looks like a fresh rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      lvl_p2  <= 1'b1;
    end else begin
      sync_p0 <= srv_i;
      sync_p1 <= sync_p0;
      lvl_p2  <= sync_p1;
    end
  end

  assign lvl  = sync_p1;
  assign rise = sync_p1 & ~lvl_p2;
  assign fall = ~sync_p1 & lvl_p2;

endmodule

// File: rtl/servo_pulse_decoder.sv
`timescale 1ns/1ps
// servo_pulse_decoder: measures each high pulse on the servo line and recovers
// the N-bit position (1 ms prefix + position steps), flagging short/long
// pulses and a missing-frame timeout.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_PER_NS = 40,
  parameter int unsigned N          = 8,
  parameter int unsigned TIMEOUT_MS = 25
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         srv_i,
  output logic [N-1:0] position_o,
  output logic         valid_o,
  output logic         err_o,
  output logic [1:0]   err_code_o,
  output logic         timeout_o
);

  localparam int unsigned MS_CYC   = ms_cyc(CLK_PER_NS);
  localparam int unsigned TICK_CYC = tick_cyc(CLK_PER_NS, N);
  localparam int unsigned MS_W     = $clog2(MS_CYC + 1);
  localparam int unsigned TICK_W   = $clog2(TICK_CYC + 1);
  localparam int unsigned GAP_W    = $clog2(TIMEOUT_MS + 1);

  localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_CYC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_CYC / 2);
  localparam logic [N-1:0]      POS_LAST  = '1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT_MS);

  // Whole steps plus a round-up bit, clamped to the largest position.
  function automatic logic [N-1:0] sat_round(input logic [N-1:0] pos,
                                             input logic round_up);
    logic [N:0] sum;
    sum = {1'b0, pos} + {{N{1'b0}}, round_up};
    return sum[N] ? {N{1'b1}} : sum[N-1:0];
  endfunction

  logic sync_lvl, sync_rise, sync_fall;

  servo_in_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .srv_i  (srv_i),
    .lvl    (sync_lvl),
    .rise   (sync_rise),
    .fall   (sync_fall)
  );

  state_t              state_q, state_d;
  logic [MS_W-1:0]     mscnt_q, mscnt_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [N-1:0]        pos_q, pos_d;
  logic [N-1:0]        position_d;
  logic                valid_d, err_d;
  logic [1:0]          code_d;
  logic [MS_W-1:0]     pre_q;
  logic [GAP_W-1:0]    gap_q;

  // Next-state, counter and strobe decode for the pulse measurement FSM.
  always_comb begin
    state_d    = state_q;
    mscnt_d    = mscnt_q;
    tick_d     = tick_q;
    pos_d      = pos_q;
    position_d = position_o;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    code_d     = err_code_o;
    if (!en_i) begin
      state_d = WAIT_LOW;
      mscnt_d = '0;
      tick_d  = '0;
      pos_d   = '0;
    end else begin
      case (state_q)
        WAIT_LOW: if (!sync_lvl) state_d = ARMED;
        ARMED: begin
          if (sync_rise) begin
            state_d = HIGH1MS;
            mscnt_d = '0;
          end
        end
        HIGH1MS: begin
          if (sync_fall) begin
            state_d = ARMED;
            if (mscnt_q < MS_LAST) begin
              err_d  = 1'b1;
              code_d = ERR_SHORT;
            end else begin
              // Prefix just completed: a zero-step pulse.
              valid_d    = 1'b1;
              position_d = '0;
            end
          end else if (mscnt_q == MS_LAST) begin
            state_d = MEASURE;
            tick_d  = '0;
            pos_d   = '0;
          end else begin
            mscnt_d = mscnt_q + MS_W'(1);
          end
        end
        MEASURE: begin
          if (sync_fall) begin
            // Half-step rounding absorbs jitter from registered generators.
            valid_d    = 1'b1;
            position_d = sat_round(pos_q, tick_q > TICK_HALF);
            state_d    = ARMED;
          end else if (pos_q == POS_LAST && tick_q == TICK_LAST) begin
            err_d   = 1'b1;
            code_d  = ERR_LONG;
            state_d = WAIT_LOW;
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            pos_d  = pos_q + N'(1);
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
        default: state_d = WAIT_LOW;
      endcase
    end
  end

  // FSM state, measurement counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= WAIT_LOW;
      mscnt_q    <= '0;
      tick_q     <= '0;
      pos_q      <= '0;
      position_o <= '0;
      valid_o    <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      state_q    <= state_d;
      mscnt_q    <= mscnt_d;
      tick_q     <= tick_d;
      pos_q      <= pos_d;
      position_o <= position_d;
      valid_o    <= valid_d;
      err_o      <= err_d;
      err_code_o <= code_d;
    end
  end

  // Free-running ms prescaler and frame-gap counter; frozen while disabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q     <= '0;
      gap_q     <= '0;
      timeout_o <= 1'b0;
    end else if (en_i) begin
      pre_q <= (pre_q == MS_LAST) ? '0 : pre_q + MS_W'(1);
      if (sync_rise) begin
        gap_q <= '0;
      end else if (pre_q == MS_LAST && gap_q != GAP_LAST) begin
        gap_q <= gap_q + GAP_W'(1);
      end
      if (valid_d) begin
        timeout_o <= 1'b0;
      end else if (gap_q == GAP_LAST) begin
        timeout_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
`timescale 1ns/1ps
// tb_servo_pulse_decoder: randomized and directed pulses against a behavioural
// pulse-length model, with a per-cycle output compare.
module tb_servo_pulse_decoder;

  // Scaled timing so every scenario fits in a short run.
  localparam int CLK_PER_NS = 5000;
  localparam int NB         = 4;
  localparam int TMO_MS     = 6;
  localparam int MS         = 1_000_000 / CLK_PER_NS;   // 200
  localparam int TICK       = MS / (2 ** NB);           // 12
  localparam int STEP       = TICK + 1;                 // 13
  localparam int PMAX       = (2 ** NB) - 1;            // 15
  localparam int LONGEST    = PMAX * STEP + TICK;       // 207
  localparam int GAP        = MS + 50;

  localparam int K_VALID = 0;
  localparam int K_SHORT = 1;
  localparam int K_LONG  = 2;

  typedef struct {
    int cyc;
    int kind;
    int pos;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          srv;
  logic [NB-1:0] position;
  logic          valid;
  logic          err;
  logic [1:0]    err_code;
  logic          timeout;

  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   mpos = 0;
  bit   tmo_chk = 1'b0;
  ev_t  exp_q[$];

  servo_pulse_decoder #(
    .CLK_PER_NS (CLK_PER_NS),
    .N          (NB),
    .TIMEOUT_MS (TMO_MS)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .srv_i      (srv),
    .position_o (position),
    .valid_o    (valid),
    .err_o      (err),
    .err_code_o (err_code),
    .timeout_o  (timeout)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input bit ok, input longint act, input longint expv);
    n_total = n_total + 1;
    if (ok) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Pulse of h clocks -> outcome, decoded position and clocks from rise to strobe.
  // Length h = 1 ms + 1 + p*step + 1 decodes to p; remainder above half a step rounds up.
  function automatic void predict(input int h, input int ms, input int tick, input int pmax,
                                  output int kind, output int pos, output int dly);
    int step, longest, extra;
    step    = tick + 1;
    longest = pmax * step + tick;
    extra   = h - ms - 2;
    pos     = 0;
    if (h <= ms) begin
      kind = K_SHORT;
      dly  = 3 + h;
    end else if (extra > longest) begin
      kind = K_LONG;
      dly  = 3 + ms + 2 + longest;
    end else begin
      kind = K_VALID;
      if (extra < 0) extra = 0;
      pos = extra / step + (((extra % step) > (tick / 2)) ? 1 : 0);
      if (pos > pmax) pos = pmax;
      dly = 3 + h;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int low, input bit tmo_mid);
    int  kind, pos, dly;
    ev_t e;
    predict(h, MS, TICK, PMAX, kind, pos, dly);
    srv   = 1'b1;
    e.cyc = cyc + dly;
    e.kind = kind;
    e.pos  = pos;
    exp_q.push_back(e);
    repeat (h - 1) step();
    if (tmo_mid) chk("timeout_held_until_valid", timeout == 1'b1, timeout, 1);
    step();
    srv = 1'b0;
    repeat (low) step();
  endtask

  // Per-cycle compare of strobes, code and held position against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      mpos = 0;
      chk("reset_zero", {position, valid, err, err_code, timeout} == '0,
          {position, valid, err, err_code, timeout}, 0);
    end else begin
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.kind == K_VALID) begin
          mpos = e.pos;
          chk("valid_strobe", valid == 1'b1 && err == 1'b0, {valid, err}, 2);
          chk("valid_position", position == e.pos[NB-1:0], position, e.pos);
          chk("valid_clears_timeout", timeout == 1'b0, timeout, 0);
        end else begin
          chk("err_strobe", err == 1'b1 && valid == 1'b0, {valid, err}, 1);
          chk("err_code", err_code == ((e.kind == K_SHORT) ? 2'b01 : 2'b10), err_code,
              (e.kind == K_SHORT) ? 1 : 2);
          chk("err_position_held", position == mpos[NB-1:0], position, mpos);
        end
      end else begin
        chk("no_strobe", valid == 1'b0 && err == 1'b0, {valid, err}, 0);
        chk("position_held", position == mpos[NB-1:0], position, mpos);
      end
      if (tmo_chk) chk("timeout_low", timeout == 1'b0, timeout, 0);
    end
  end

  initial begin
    int k, p, d;
    rst_n = 1'b0;
    en    = 1'b1;
    srv   = 1'b0;

    // Pin the model against hand-computed values at the default timing.
    predict(25001 + 128 * 98 + 1, 25000, 97, 255, k, p, d);
    chk("model_pos128", k == K_VALID && p == 128, p, 128);
    predict(25001 + 128 * 98 + 1 - 40, 25000, 97, 255, k, p, d);
    chk("model_jitter_minus", k == K_VALID && p == 128, p, 128);
    predict(25002, 25000, 97, 255, k, p, d);
    chk("model_pos0", k == K_VALID && p == 0, p, 0);
    predict(25001 + 255 * 98 + 1, 25000, 97, 255, k, p, d);
    chk("model_pos255", k == K_VALID && p == 255, p, 255);
    predict(10000, 25000, 97, 255, k, p, d);
    chk("model_short", k == K_SHORT, k, K_SHORT);
    predict(25001 + 300 * 98, 25000, 97, 255, k, p, d);
    chk("model_long", k == K_LONG, k, K_LONG);
    predict(409, 200, 12, 15, k, p, d);
    chk("model_fall_at_saturation", k == K_VALID && p == 15, p, 15);
    predict(410, 200, 12, 15, k, p, d);
    chk("model_long_edge", k == K_LONG && d == 412, d, 412);

    repeat (5) step();
    chk("reset_outputs", {position, valid, err, err_code, timeout} == '0,
        {position, valid, err, err_code, timeout}, 0);
    rst_n = 1'b1;
    repeat (50) step();
    tmo_chk = 1'b1;

    // Mid-scale, zero and full-scale pulses, then the same with jitter.
    pulse(MS + 1 + 8 * STEP + 1, GAP, 1'b0);
    pulse(MS + 2, GAP, 1'b0);
    pulse(MS + 1 + PMAX * STEP + 1, GAP, 1'b0);
    pulse(MS + 2 + 8 * STEP - 5, GAP, 1'b0);
    pulse(MS + 2 + 8 * STEP + 5, GAP, 1'b0);
    pulse(MS + 2 + PMAX * STEP + 5, GAP, 1'b0);
    pulse(MS + 2 + 5, GAP, 1'b0);
    // Fall in the saturation cycle, then one clock past it.
    pulse(MS + 2 + LONGEST, GAP, 1'b0);
    pulse(MS + 3 + LONGEST, GAP, 1'b0);
    // Short pulses, including the last short length.
    pulse(80, GAP, 1'b0);
    pulse(MS, GAP, 1'b0);
    // Overlong pulse, then recovery.
    pulse(MS + 1 + 20 * STEP, GAP, 1'b0);
    pulse(MS + 2 + 4 * STEP, GAP, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int r, h;
      r = $urandom_range(0, 9);
      if (r == 0)      h = $urandom_range(2, MS);
      else if (r == 1) h = $urandom_range(MS + 3 + LONGEST, MS + 60 + LONGEST);
      else             h = $urandom_range(MS + 2, MS + 2 + LONGEST);
      pulse(h, $urandom_range(MS, MS + 150), 1'b0);
    end

    // Idle line raises timeout; the next good pulse clears it with its strobe.
    tmo_chk = 1'b0;
    repeat (TMO_MS * (MS + 1) + 10) step();
    chk("timeout_set", timeout == 1'b1, timeout, 1);
    pulse(MS + 2 + 6 * STEP, GAP, 1'b1);
    chk("timeout_cleared", timeout == 1'b0, timeout, 0);
    tmo_chk = 1'b1;

    // Disable mid-measure, re-enable while the line is still high.
    srv = 1'b1;
    repeat (MS + 60) step();
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    repeat (30) step();
    srv = 1'b0;
    repeat (GAP) step();
    pulse(MS + 2 + 3 * STEP, GAP, 1'b0);

    // Reset mid-measure, released while the line is still high.
    srv = 1'b1;
    repeat (MS + 60) step();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (4) step();
    rst_n = 1'b1;
    repeat (30) step();
    srv = 1'b0;
    repeat (GAP) step();
    pulse(MS + 2 + 9 * STEP, GAP, 1'b0);

    repeat (20) step();
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
